// File: rtl/ctrl_lut_prog.sv
// ============================================================================
// ctrl_lut_prog : programmable control-word lookup table with sweep clear
// Revision      : 1.0
// ============================================================================
`default_nettype none

module ctrl_lut_prog #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_req,
    input  logic              prog_valid,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W-1:0] prog_data,
    output logic              prog_ready,
    input  logic              lk_valid,
    input  logic [ADDR_W-1:0] lk_addr,
    output logic              lk_ready,
    output logic              lk_out_valid,
    output logic [DATA_W-1:0] lk_data,
    output logic              busy
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] SWEEP_LAST = '1;

    typedef enum logic [0:0] {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] sweep_q, sweep_d;
    logic [DATA_W-1:0] lk_data_q, lk_data_d;
    logic              lk_out_valid_q, lk_out_valid_d;
    logic [DATA_W-1:0] table_q [DEPTH];

    logic              accept;
    logic              prog_fire;
    logic              lk_fire;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    assign accept     = (state_q == ST_READY) && !clr_req;
    assign prog_ready = accept;
    assign lk_ready   = accept;
    assign busy       = (state_q == ST_INIT);
    assign prog_fire  = prog_valid && accept;
    assign lk_fire    = lk_valid && accept;

    assign lk_data      = lk_data_q;
    assign lk_out_valid = lk_out_valid_q;

    always_comb begin
        state_d        = state_q;
        sweep_d        = sweep_q;
        lk_data_d      = lk_data_q;
        lk_out_valid_d = 1'b0;
        wr_en          = 1'b0;
        wr_addr        = prog_addr;
        wr_data        = prog_data;

        if (state_q == ST_INIT) begin
            // One entry zeroed per cycle; clr_req is ignored while sweeping.
            wr_en   = 1'b1;
            wr_addr = sweep_q;
            wr_data = '0;
            if (sweep_q == SWEEP_LAST) begin
                state_d = ST_READY;
                sweep_d = '0;
            end else begin
                sweep_d = sweep_q + 1'b1;
            end
        end else if (clr_req) begin
            state_d = ST_INIT;
            sweep_d = '0;
        end else begin
            wr_en          = prog_fire;
            lk_out_valid_d = lk_fire;
            if (lk_fire) begin
                // Write-first: a same-cycle write to the looked-up entry wins.
                if (prog_fire && (prog_addr == lk_addr)) begin
                    lk_data_d = prog_data;
                end else begin
                    lk_data_d = table_q[lk_addr];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_INIT;
            sweep_q        <= '0;
            lk_data_q      <= '0;
            lk_out_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            sweep_q        <= sweep_d;
            lk_data_q      <= lk_data_d;
            lk_out_valid_q <= lk_out_valid_d;
        end
    end

    // Storage has no reset; the INIT sweep zeroes it after reset release.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            table_q[wr_addr] <= wr_data;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ctrl_lut_prog.sv
// ============================================================================
// tb_ctrl_lut_prog : randomized self-checking bench for ctrl_lut_prog
// Revision         : 1.0
// ============================================================================
`default_nettype none

module tb_ctrl_lut_prog;

    localparam int DEPTH = 64;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clr_req = 1'b0;
    logic       prog_valid = 1'b0;
    logic [5:0] prog_addr = '0;
    logic [3:0] prog_data = '0;
    logic       prog_ready;
    logic       lk_valid = 1'b0;
    logic [5:0] lk_addr = '0;
    logic       lk_ready;
    logic       lk_out_valid;
    logic [3:0] lk_data;
    logic       busy;

    logic       b_rst_n = 1'b0;
    logic       b_clr_req = 1'b0;
    logic       b_prog_valid = 1'b0;
    logic [1:0] b_prog_addr = '0;
    logic [7:0] b_prog_data = '0;
    logic       b_prog_ready;
    logic       b_lk_valid = 1'b0;
    logic [1:0] b_lk_addr = '0;
    logic       b_lk_ready;
    logic       b_lk_out_valid;
    logic [7:0] b_lk_data;
    logic       b_busy;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: cycles of clearing left, table image, output regs.
    int         m_clear_left;
    logic [3:0] m_mem [DEPTH];
    logic [3:0] m_ld;
    logic       m_lv;

    always #5 clk = ~clk;

    ctrl_lut_prog #(.ADDR_W(6), .DATA_W(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .clr_req(clr_req),
        .prog_valid(prog_valid), .prog_addr(prog_addr), .prog_data(prog_data),
        .prog_ready(prog_ready), .lk_valid(lk_valid), .lk_addr(lk_addr),
        .lk_ready(lk_ready), .lk_out_valid(lk_out_valid), .lk_data(lk_data),
        .busy(busy)
    );

    ctrl_lut_prog #(.ADDR_W(2), .DATA_W(8)) u_dut_small (
        .clk(clk), .rst_n(b_rst_n), .clr_req(b_clr_req),
        .prog_valid(b_prog_valid), .prog_addr(b_prog_addr), .prog_data(b_prog_data),
        .prog_ready(b_prog_ready), .lk_valid(b_lk_valid), .lk_addr(b_lk_addr),
        .lk_ready(b_lk_ready), .lk_out_valid(b_lk_out_valid), .lk_data(b_lk_data),
        .busy(b_busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Asynchronous reset entered mid-cycle, released just after a rising edge.
    task automatic apply_reset();
        rst_n = 1'b0;
        #3;
        check("rst_busy", busy, 1);
        check("rst_prog_ready", prog_ready, 0);
        check("rst_lk_ready", lk_ready, 0);
        check("rst_lk_out_valid", lk_out_valid, 0);
        check("rst_lk_data", lk_data, 0);
        m_clear_left = DEPTH;
        m_ld = '0;
        m_lv = 1'b0;
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // One clock cycle: drive, check handshakes, advance model, check outputs.
    task automatic step(input logic clr, input logic pv, input logic [5:0] pa,
                        input logic [3:0] pd, input logic lv, input logic [5:0] la);
        logic rdy;
        clr_req = clr; prog_valid = pv; prog_addr = pa; prog_data = pd;
        lk_valid = lv; lk_addr = la;
        #1;
        rdy = (m_clear_left == 0) && !clr;
        check("busy", busy, (m_clear_left > 0));
        check("prog_ready", prog_ready, rdy);
        check("lk_ready", lk_ready, rdy);
        if (m_clear_left > 0) begin
            m_clear_left--;
            m_lv = 1'b0;
        end else if (clr) begin
            m_clear_left = DEPTH;
            m_lv = 1'b0;
            for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        end else begin
            m_lv = lv;
            if (lv) m_ld = (pv && pa == la) ? pd : m_mem[la];
            if (pv) m_mem[pa] = pd;
        end
        @(posedge clk);
        #1;
        check("lk_out_valid", lk_out_valid, m_lv);
        check("lk_data", lk_data, m_ld);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 6'd0, 4'd0, 1'b0, 6'd0);
    endtask

    initial begin
        logic [7:0] vals [4];

        // Lookup held high through the whole initial sweep, then read 0x2A.
        lk_valid = 1'b1;
        apply_reset();
        repeat (DEPTH) step(1'b0, 1'b0, 6'd0, 4'd0, 1'b1, 6'($urandom));
        step(1'b0, 1'b0, 6'd0, 4'd0, 1'b1, 6'h2A);

        // Program then look up next cycle.
        step(1'b0, 1'b1, 6'h23, 4'b1010, 1'b0, 6'd0);
        step(1'b0, 1'b0, 6'd0, 4'd0, 1'b1, 6'h23);
        idle();

        // Same-cycle write/lookup: equal and different addresses.
        step(1'b0, 1'b1, 6'h06, 4'b0011, 1'b0, 6'd0);
        step(1'b0, 1'b1, 6'h05, 4'b0111, 1'b1, 6'h05);
        step(1'b0, 1'b1, 6'h05, 4'b1001, 1'b1, 6'h06);
        step(1'b0, 1'b0, 6'd0, 4'd0, 1'b1, 6'h05);

        // Fill several entries, clear with a colliding write, hammer while busy.
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 6'(i * 5 + 1), 4'($urandom_range(1, 15)), 1'b0, 6'd0);
        step(1'b1, 1'b1, 6'h10, 4'hF, 1'b1, 6'h10);
        repeat (DEPTH) step(1'($urandom), 1'b1, 6'($urandom), 4'($urandom), 1'b1, 6'($urandom));
        for (int a = 0; a < DEPTH; a++) step(1'b0, 1'b0, 6'd0, 4'd0, 1'b1, 6'(a));

        // Randomized traffic on a narrow address window to force collisions.
        for (int n = 0; n < 400; n++) begin
            step(($urandom_range(0, 59) == 0), 1'($urandom), 6'($urandom_range(0, 7)),
                 4'($urandom), 1'($urandom), 6'($urandom_range(0, 7)));
        end
        repeat (DEPTH) idle();

        // Reset in READY with nonzero lk_data, then again at sweep count 30.
        step(1'b0, 1'b1, 6'h09, 4'hC, 1'b0, 6'd0);
        step(1'b0, 1'b0, 6'd0, 4'd0, 1'b1, 6'h09);
        apply_reset();
        repeat (30) step(1'b0, 1'b1, 6'($urandom), 4'($urandom), 1'b1, 6'($urandom));
        apply_reset();
        repeat (DEPTH) step(1'b0, 1'b0, 6'd0, 4'd0, 1'b1, 6'($urandom));
        step(1'b0, 1'b1, 6'h3F, 4'h5, 1'b1, 6'h3F);
        step(1'b0, 1'b0, 6'd0, 4'd0, 1'b1, 6'h00);
        idle();

        // Small configuration: 4-entry sweep, then full program/readback.
        #3;
        check("s_rst_busy", b_busy, 1);
        check("s_rst_ready", b_prog_ready, 0);
        @(posedge clk);
        #1;
        b_rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("s_init_busy", b_busy, 1);
            @(posedge clk);
            #1;
        end
        #1;
        check("s_ready_busy", b_busy, 0);
        check("s_prog_ready", b_prog_ready, 1);
        check("s_lk_ready", b_lk_ready, 1);
        for (int i = 0; i < 4; i++) begin
            vals[i] = 8'($urandom);
            b_prog_valid = 1'b1; b_prog_addr = 2'(i); b_prog_data = vals[i];
            @(posedge clk);
            #1;
        end
        b_prog_valid = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            b_lk_valid = 1'b1; b_lk_addr = 2'(i);
            @(posedge clk);
            #1;
            check("s_lk_out_valid", b_lk_out_valid, 1);
            check("s_lk_data", b_lk_data, vals[i]);
        end
        b_lk_valid = 1'b0;
        @(posedge clk);
        #1;
        check("s_idle_valid", b_lk_out_valid, 0);
        check("s_hold_data", b_lk_data, vals[0]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
